// File: rtl/rc522_pkg.sv
// Shared constants and FSM encoding for the RC522 register-interface responder.
package rc522_pkg;

    localparam logic [5:0]  ADDR_VERSION = 6'h37;
    localparam int unsigned RW_BIT       = 7;
    localparam int unsigned ADDR_MSB     = 6;
    localparam int unsigned ADDR_LSB     = 1;

    // RC522 register map entries also used by the RFID core
    localparam logic [5:0] COMMAND_REG    = 6'h01;
    localparam logic [5:0] COM_IRQ_REG    = 6'h04;
    localparam logic [5:0] FIFO_DATA_REG  = 6'h09;
    localparam logic [5:0] FIFO_LEVEL_REG = 6'h0A;
    localparam logic [5:0] BIT_FRAMING_REG= 6'h0D;
    localparam logic [5:0] MODE_REG       = 6'h11;
    localparam logic [5:0] TX_MODE_REG    = 6'h12;
    localparam logic [5:0] RX_MODE_REG    = 6'h13;
    localparam logic [5:0] TX_CONTROL_REG = 6'h14;
    localparam logic [5:0] TX_ASK_REG     = 6'h15;
    localparam logic [5:0] T_MODE_REG     = 6'h2A;
    localparam logic [5:0] T_PRESCALER_REG= 6'h2B;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        ADDR      = 3'd2,
        WDATA     = 3'd3,
        RDATA     = 3'd4,
        IGNORE    = 3'd5
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with one-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/rc522_spi_slave.sv
// SPI mode-0 responder modelling the RC522 64x8 register file: serves reads on
// MISO, commits writes, and reports each committed write to the core.
module rc522_spi_slave
    import rc522_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  VERSION_VAL = 8'h92
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       reg_wr_strobe,
    output logic [5:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    input  logic [5:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       frame_err
);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d_i      (spi_clk),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d_i      (ss),
        .rise_o   (ss_rise),
        .fall_o   (ss_fall)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [5:0] addr_q, addr_d;
    logic       err_q, err_d;
    logic       stb_q, stb_d;
    logic [5:0] wa_q, wa_d;
    logic [7:0] wd_q, wd_d;
    logic [7:0] regs_q [64];

    logic [7:0] rx_byte;
    logic [5:0] rd_addr;
    logic [7:0] rd_val;
    logic       we;

    assign rx_byte = {rx_q, mosi_s};
    assign rd_addr = rx_byte[ADDR_MSB:ADDR_LSB];
    assign rd_val  = (rd_addr == ADDR_VERSION) ? VERSION_VAL : regs_q[rd_addr];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        err_d     = err_q;
        stb_d     = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        we        = 1'b0;
        // The synchroniser resets low, so an idle-high ss always produces a rise
        // after reset; that rise is what releases WAIT_IDLE.
        if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (ss_fall) begin
                    state_d   = ADDR;
                    bit_cnt_d = '0;
                    err_d     = 1'b0;
                    tx_d      = '0;
                end
                ADDR, WDATA, RDATA: begin
                    if (sclk_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == WDATA) begin
                                if (addr_q != ADDR_VERSION) begin
                                    we    = 1'b1;
                                    stb_d = 1'b1;
                                    wa_d  = addr_q;
                                    wd_d  = rx_byte;
                                end
                            end else if (rx_byte[0]) begin
                                err_d   = 1'b1;
                                state_d = IGNORE;
                            end else begin
                                addr_d = rd_addr;
                                if (state_q == RDATA || rx_byte[RW_BIT]) begin
                                    tx_d    = rd_val;
                                    state_d = RDATA;
                                end else begin
                                    state_d = WDATA;
                                end
                            end
                        end
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q   <= WAIT_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            stb_q     <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            for (int unsigned i = 0; i < 64; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            stb_q     <= stb_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            if (we) regs_q[addr_q] <= rx_byte;
        end
    end

    assign busy          = (state_q == ADDR) || (state_q == WDATA) ||
                           (state_q == RDATA) || (state_q == IGNORE);
    assign miso_oe       = busy;
    assign miso          = busy && (state_q != IGNORE) && tx_q[7];
    assign reg_wr_strobe = stb_q;
    assign reg_wr_addr   = wa_q;
    assign reg_wr_data   = wd_q;
    assign frame_err     = err_q;
    assign dbg_data      = (dbg_addr == ADDR_VERSION) ? VERSION_VAL : regs_q[dbg_addr];

endmodule

// File: tb/tb_rc522_spi_slave.sv
// Directed bench for rc522_spi_slave: writes checked through a strobe scoreboard,
// reads checked against expected MISO bytes queued before each frame.
module tb_rc522_spi_slave;

    localparam int HALF = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       spi_clk  = 1'b0;
    logic       ss       = 1'b1;
    logic       mosi     = 1'b0;
    logic       miso, miso_oe, reg_wr_strobe, busy, frame_err;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [5:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        wr_q[$];
    logic [7:0] miso_q[$];

    rc522_spi_slave #(.SYNC_STAGES(2), .VERSION_VAL(8'h92)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .spi_clk       (spi_clk),
        .ss            (ss),
        .mosi          (mosi),
        .miso          (miso),
        .miso_oe       (miso_oe),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (reset && reg_wr_strobe === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected_strobe", 32'(reg_wr_strobe), 32'd0);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(reg_wr_addr), 32'(e.a));
                chk("wr_data", 32'(reg_wr_data), 32'(e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(HALF);
            r[i] = miso;
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(HALF);
    endtask

    task automatic ss_high();
        tick(HALF);
        ss = 1'b1;
        tick(HALF + 4);
    endtask

    task automatic xfer_chk(input logic [7:0] b, input string tag);
        logic [7:0] r;
        logic [7:0] e;
        spi_bits(b, 8, r);
        if (miso_q.size() == 0) begin
            chk({tag, "_no_expect"}, 32'(miso_q.size()), 32'd1);
        end else begin
            e = miso_q.pop_front();
            chk(tag, 32'(r), 32'(e));
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] r;
        wr_q.push_back('{a: a, d: d});
        ss_low();
        spi_bits({1'b0, a, 1'b0}, 8, r);
        spi_bits(d, 8, r);
        ss_high();
    endtask

    task automatic chk_dbg(input logic [5:0] a, input logic [7:0] exp, input string tag);
        dbg_addr = a;
        tick(1);
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] r;

        // Reset state
        tick(3);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_strobe", 32'(reg_wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_dbg_zero", 32'(dbg_data), 32'd0);
        chk_dbg(6'h37, 8'h92, "rst_version");
        reset = 1'b1;
        tick(10);

        // Write TxModeReg
        wr_q.push_back('{a: 6'h12, d: 8'h80});
        ss_low();
        chk("frame_busy", 32'(busy), 32'd1);
        chk("frame_miso_oe", 32'(miso_oe), 32'd1);
        spi_bits(8'h24, 8, r);
        spi_bits(8'h80, 8, r);
        ss_high();
        chk("post_busy", 32'(busy), 32'd0);
        chk_dbg(6'h12, 8'h80, "dbg_12");

        // Read-back TxControlReg
        do_write(6'h14, 8'h83);
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h83);
        ss_low();
        xfer_chk(8'hA8, "rd14_b0");
        xfer_chk(8'h00, "rd14_b1");
        ss_high();

        // VersionReg
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h92);
        ss_low();
        xfer_chk(8'hEE, "ver_b0");
        xfer_chk(8'h00, "ver_b1");
        ss_high();

        // Continuous read
        do_write(6'h12, 8'h11);
        do_write(6'h13, 8'h22);
        miso_q.push_back(8'h00);
        miso_q.push_back(8'h11);
        miso_q.push_back(8'h22);
        ss_low();
        xfer_chk(8'hA4, "cont_b0");
        xfer_chk(8'hA6, "cont_b1");
        xfer_chk(8'h00, "cont_b2");
        ss_high();

        // Aborted frame: partial data byte is dropped
        ss_low();
        spi_bits(8'h2A, 8, r);
        spi_bits(8'hFF, 5, r);
        ss_high();
        chk_dbg(6'h15, 8'h00, "abort_reg15");
        do_write(6'h15, 8'h5A);
        chk_dbg(6'h15, 8'h5A, "after_abort_reg15");

        // Malformed address byte
        ss_low();
        spi_bits(8'h25, 8, r);
        chk("bad_err_in_frame", 32'(frame_err), 32'd1);
        spi_bits(8'h55, 8, r);
        ss_high();
        chk("bad_err_sticky", 32'(frame_err), 32'd1);
        chk_dbg(6'h12, 8'h11, "bad_reg12");
        wr_q.push_back('{a: 6'h16, d: 8'h3C});
        ss_low();
        chk("bad_err_cleared", 32'(frame_err), 32'd0);
        spi_bits(8'h2C, 8, r);
        spi_bits(8'h3C, 8, r);
        ss_high();
        chk_dbg(6'h16, 8'h3C, "dbg_16");

        // Writes to VersionReg are dropped
        ss_low();
        spi_bits(8'h6E, 8, r);
        spi_bits(8'h00, 8, r);
        ss_high();
        chk_dbg(6'h37, 8'h92, "ver_unchanged");

        // Reset mid-frame
        ss_low();
        spi_bits(8'h2E, 3, r);
        reset = 1'b0;
        tick(3);
        chk("mid_miso", 32'(miso), 32'd0);
        chk("mid_miso_oe", 32'(miso_oe), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_frame_err", 32'(frame_err), 32'd0);
        chk("mid_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("mid_wr_data", 32'(reg_wr_data), 32'd0);
        chk_dbg(6'h12, 8'h00, "mid_reg12_cleared");
        reset = 1'b1;
        tick(10);
        spi_bits(8'hFF, 5, r);
        chk("wait_busy", 32'(busy), 32'd0);
        spi_bits(8'h99, 8, r);
        chk("wait_miso_oe", 32'(miso_oe), 32'd0);
        ss_high();
        chk_dbg(6'h17, 8'h00, "wait_reg17");
        do_write(6'h17, 8'hC3);
        chk_dbg(6'h17, 8'hC3, "after_rst_reg17");
        miso_q.push_back(8'h00);
        miso_q.push_back(8'hC3);
        ss_low();
        xfer_chk(8'hAE, "rd17_b0");
        xfer_chk(8'h00, "rd17_b1");
        ss_high();

        tick(5);
        chk("wr_pending", 32'(wr_q.size()), 32'd0);
        chk("miso_pending", 32'(miso_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
